// File: rtl/tune_sequencer.sv
// tune_sequencer: slews the NCO phase increment toward a SPI-supplied target in
// bounded steps, one step per audio sample tick, and owns the 3-bit receiver gain.
// Build option: define TUNE_SEQ_AGC_EN to build the envelope-driven AGC loop; when
// it is undefined, gain is purely manual (cfg_gain loaded on cfg_valid).
`timescale 1ns/1ps
module tune_sequencer #(
    parameter logic [19:0] STEP         = 20'd256,
    parameter int          SETTLE_TICKS = 8,
    parameter logic [7:0]  AGC_HI       = 8'd200,
    parameter logic [7:0]  AGC_LO       = 8'd40,
    parameter int          AGC_HOLD     = 4
) (
    input  logic        CLK,
    input  logic        RSTb,
    input  logic        cfg_valid,
    input  logic [19:0] cfg_phase_inc,
    input  logic [2:0]  cfg_gain,
    input  logic        cfg_agc,
    input  logic        tick,
    input  logic [7:0]  env_level,
    output logic [19:0] phase_inc,
    output logic [2:0]  gain,
    output logic        busy
);

    localparam logic [1:0]  IDLE      = 2'd0;
    localparam logic [1:0]  RAMP      = 2'd1;
    localparam logic [1:0]  SETTLE    = 2'd2;
    localparam logic [19:0] PHASE_RST = 20'h2735;
    localparam logic [2:0]  GAIN_RST  = 3'd5;

    localparam int               SET_W    = (SETTLE_TICKS < 1) ? 1 : $clog2(SETTLE_TICKS + 1);
    localparam logic [SET_W-1:0] SET_INIT = SET_W'(SETTLE_TICKS);

    logic [1:0]       state_q, state_d;
    logic [19:0]      phase_q, phase_d;
    logic [19:0]      target_q, target_d;
    logic [2:0]       gain_q, gain_d;
    logic [SET_W-1:0] settle_q, settle_d;
    logic             busy_q;

`ifdef TUNE_SEQ_AGC_EN
    // Out-of-band counters only need to count to AGC_HOLD-1; reaching the hold
    // count steps the gain and clears the counter in the same tick.
    localparam int                HOLD_W    = (AGC_HOLD < 2) ? 1 : $clog2(AGC_HOLD);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(AGC_HOLD - 1);

    logic              agc_mode_q, agc_mode_d;
    logic [HOLD_W-1:0] hi_cnt_q, hi_cnt_d;
    logic [HOLD_W-1:0] lo_cnt_q, lo_cnt_d;

    function automatic logic [2:0] gain_step(input logic [2:0] g, input logic up);
        if (up) return (g == 3'd7) ? g : g + 3'd1;
        else    return (g == 3'd0) ? g : g - 3'd1;
    endfunction
`else
    // AGC-only inputs have no consumer in the manual-gain build.
    logic unused_agc_inputs;
    assign unused_agc_inputs = ^{cfg_agc, env_level};
`endif

    // One bounded move toward the target; lands exactly when within STEP, so
    // there is never an overshoot and the comparison never wraps.
    function automatic logic [19:0] ramp_step(input logic [19:0] cur, input logic [19:0] tgt);
        if (tgt >= cur) return ((tgt - cur) <= STEP) ? tgt : cur + STEP;
        else            return ((cur - tgt) <= STEP) ? tgt : cur - STEP;
    endfunction

    // Next-state logic: configuration has priority over a coincident tick.
    always_comb begin
        state_d  = state_q;
        phase_d  = phase_q;
        target_d = target_q;
        gain_d   = gain_q;
        settle_d = settle_q;
`ifdef TUNE_SEQ_AGC_EN
        agc_mode_d = agc_mode_q;
        hi_cnt_d   = hi_cnt_q;
        lo_cnt_d   = lo_cnt_q;
`endif
        if (cfg_valid) begin
            target_d = cfg_phase_inc;
            state_d  = RAMP;
            settle_d = '0;
`ifdef TUNE_SEQ_AGC_EN
            agc_mode_d = cfg_agc;
            hi_cnt_d   = '0;
            lo_cnt_d   = '0;
            if (!cfg_agc) gain_d = cfg_gain;
`else
            gain_d = cfg_gain;
`endif
        end else if (tick) begin
            case (state_q)
                RAMP: begin
                    phase_d = ramp_step(phase_q, target_q);
                    if (phase_d == target_q) begin
                        state_d  = SETTLE;
                        settle_d = SET_INIT;
                    end
                end
                SETTLE: begin
                    if (settle_q <= SET_W'(1)) begin
                        settle_d = '0;
                        state_d  = IDLE;
                    end else begin
                        settle_d = settle_q - SET_W'(1);
                    end
                end
                IDLE: begin
`ifdef TUNE_SEQ_AGC_EN
                    // AGC runs only while idle so gain never moves mid-retune.
                    if (agc_mode_q) begin
                        if (env_level > AGC_HI) begin
                            lo_cnt_d = '0;
                            if (hi_cnt_q == HOLD_LAST) begin
                                hi_cnt_d = '0;
                                gain_d   = gain_step(gain_q, 1'b0);
                            end else begin
                                hi_cnt_d = hi_cnt_q + HOLD_W'(1);
                            end
                        end else if (env_level < AGC_LO) begin
                            hi_cnt_d = '0;
                            if (lo_cnt_q == HOLD_LAST) begin
                                lo_cnt_d = '0;
                                gain_d   = gain_step(gain_q, 1'b1);
                            end else begin
                                lo_cnt_d = lo_cnt_q + HOLD_W'(1);
                            end
                        end else begin
                            hi_cnt_d = '0;
                            lo_cnt_d = '0;
                        end
                    end
`endif
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State and output registers; busy is a registered decode of the next state.
    always_ff @(posedge CLK) begin
        if (!RSTb) begin
            state_q  <= IDLE;
            phase_q  <= PHASE_RST;
            target_q <= PHASE_RST;
            gain_q   <= GAIN_RST;
            settle_q <= '0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            phase_q  <= phase_d;
            target_q <= target_d;
            gain_q   <= gain_d;
            settle_q <= settle_d;
            busy_q   <= (state_d != IDLE);
        end
    end

`ifdef TUNE_SEQ_AGC_EN
    // AGC mode flag and out-of-band hold counters.
    always_ff @(posedge CLK) begin
        if (!RSTb) begin
            agc_mode_q <= 1'b0;
            hi_cnt_q   <= '0;
            lo_cnt_q   <= '0;
        end else begin
            agc_mode_q <= agc_mode_d;
            hi_cnt_q   <= hi_cnt_d;
            lo_cnt_q   <= lo_cnt_d;
        end
    end
`endif

    assign phase_inc = phase_q;
    assign gain      = gain_q;
    assign busy      = busy_q;

endmodule
